// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// Module : aes_pkg
// Brief  : Shared AES datapath widths and serializer state encoding.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_WORDS   = AES_BLOCK_W / AES_WORD_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } aes_state_e;

endpackage : aes_pkg

`default_nettype wire

// File: rtl/aes_out_serializer.sv
//------------------------------------------------------------------------------
// Module : aes_out_serializer
// Brief  : Splits an AES block into words, most-significant word first.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int WIDTH   = AES_WORD_W,
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid_i,
    input  logic [BLOCK_W-1:0] blk_data_i,
    output logic               blk_ready_o,
    output logic               word_valid_o,
    output logic [WIDTH-1:0]   word_data_o,
    output logic [1:0]         word_idx_o,
    output logic               word_last_o,
    input  logic               word_ready_i
);

    localparam int         WORDS    = BLOCK_W / WIDTH;
    localparam logic [1:0] LAST_IDX = 2'(WORDS - 1);

    if ((BLOCK_W % WIDTH) != 0) begin : g_bad_width
        $error("BLOCK_W must be a multiple of WIDTH");
    end

    aes_state_e         r_state;
    logic [1:0]         r_idx;
    logic [BLOCK_W-1:0] r_hold;

    logic w_send;
    logic w_last;
    logic w_blk_hs;
    logic w_word_hs;

    assign w_send    = (r_state == SEND);
    assign w_last    = w_send && (r_idx == LAST_IDX);
    assign w_word_hs = w_send && word_ready_i;
    assign w_blk_hs  = blk_valid_i && blk_ready_o;

    // A new block may enter on the same edge the final word leaves.
    assign blk_ready_o  = !w_send || (w_last && word_ready_i);
    assign word_valid_o = w_send;
    assign word_last_o  = w_last;
    assign word_idx_o   = r_idx;

    always_comb begin
        word_data_o = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == 2'(k)) begin
                word_data_o = r_hold[BLOCK_W-1-k*WIDTH -: WIDTH];
            end
        end
    end

    // Index stays at the last value when returning to IDLE; only a new block rewinds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_hold  <= '0;
        end else if (w_blk_hs) begin
            r_state <= SEND;
            r_idx   <= 2'd0;
            r_hold  <= blk_data_i;
        end else if (w_word_hs) begin
            if (w_last) begin
                r_state <= IDLE;
            end else begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

endmodule : aes_out_serializer

`default_nettype wire

// File: tb/tb_aes_out_serializer.sv
//------------------------------------------------------------------------------
// Module : tb_aes_out_serializer
// Brief  : Word-queue reference model bench for aes_out_serializer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_out_serializer;

    logic         clk;
    logic         rst;
    logic         blk_valid_i;
    logic [127:0] blk_data_i;
    logic         blk_ready_o;
    logic         word_valid_o;
    logic [31:0]  word_data_o;
    logic [1:0]   word_idx_o;
    logic         word_last_o;
    logic         word_ready_i;

    int n_checks;
    int n_fail;

    // Words still owed downstream, oldest first.
    logic [31:0] q_words[$];

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

    aes_out_serializer #(.WIDTH(32), .BLOCK_W(128)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid_i  (blk_valid_i),
        .blk_data_i   (blk_data_i),
        .blk_ready_o  (blk_ready_o),
        .word_valid_o (word_valid_o),
        .word_data_o  (word_data_o),
        .word_idx_o   (word_idx_o),
        .word_last_o  (word_last_o),
        .word_ready_i (word_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then advance the model on the edge.
    task automatic step(input logic bv, input logic [127:0] bd, input logic wr);
        logic exp_ready;
        logic word_hs;
        logic blk_hs;
        blk_valid_i  = bv;
        blk_data_i   = bd;
        word_ready_i = wr;
        #1;
        exp_ready = (q_words.size() == 0) || (q_words.size() == 1 && wr);
        check("word_valid", 128'(word_valid_o), 128'(q_words.size() != 0));
        check("blk_ready", 128'(blk_ready_o), 128'(exp_ready));
        if (q_words.size() != 0) begin
            check("word_data", 128'(word_data_o), 128'(q_words[0]));
            check("word_idx", 128'(word_idx_o), 128'(4 - q_words.size()));
            check("word_last", 128'(word_last_o), 128'(q_words.size() == 1));
        end
        word_hs = (q_words.size() != 0) && wr;
        blk_hs  = bv && exp_ready;
        @(posedge clk);
        if (word_hs) void'(q_words.pop_front());
        if (blk_hs) begin
            for (int k = 3; k >= 0; k--) q_words.push_back(bd[k*32 +: 32]);
        end
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        blk_valid_i  = 1'b0;
        blk_data_i   = '0;
        word_ready_i = 1'b0;
        #2;
        check("rst_valid", 128'(word_valid_o), 128'(0));
        check("rst_ready", 128'(blk_ready_o), 128'(1));
        check("rst_data", 128'(word_data_o), 128'(0));
        check("rst_idx", 128'(word_idx_o), 128'(0));
        check("rst_last", 128'(word_last_o), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic order with a free-running consumer.
        step(1'b1, BLK_A, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Stall three cycles on word 1.
        step(1'b1, BLK_A, 1'b1);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            check("stall_data", 128'(word_data_o), 128'(32'h44556677));
            check("stall_idx", 128'(word_idx_o), 128'(1));
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        // Back-to-back blocks: second block held valid until the last-word edge.
        step(1'b1, BLK_A, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, BLK_B, 1'b1);
        check("b2b_first", 128'(word_data_o), 128'(32'hFFEEDDCC));
        check("b2b_valid", 128'(word_valid_o), 128'(1));
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Offer while stalled in SEND must be ignored.
        step(1'b1, BLK_A, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, BLK_B, 1'b0);
        check("ignore_data", 128'(word_data_o), 128'(32'h00112233));
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Reset mid-block after word 1.
        step(1'b1, BLK_A, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        rst = 1'b1;
        #1;
        q_words.delete();
        check("midrst_valid", 128'(word_valid_o), 128'(0));
        check("midrst_ready", 128'(blk_ready_o), 128'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_aes_out_serializer

`default_nettype wire
